// File: rtl/inst_fetch_unit_pkg.sv
// Shared opcodes, fetch FSM encodings and the instruction-queue entry type
// used by the fetch unit and its queue.
package inst_fetch_unit_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL_OP    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  typedef struct packed {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] word;
  } iq_entry_t;

  // Sign-extended J-type immediate.
  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Memory-request/response and decoder-facing handshake bundle of the fetch unit.
// master = fetch unit side, slave = memory controller + decoder side.
interface inst_fetch_unit_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_taken;
  logic        inst_ready;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output inst_valid, inst, inst_pc, inst_pred_taken,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  inst_valid, inst, inst_pc, inst_pred_taken,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit_queue.sv
// Synchronous FIFO of {pred,pc,word}; clear beats push/pop, push+pop is legal when full.
module inst_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  logic      i_en,
  input  logic      i_push,
  input  logic      i_pop,
  input  logic      i_clear,
  input  iq_entry_t i_data,
  output logic      o_full,
  output logic      o_empty,
  output logic [AW:0] o_count,
  output iq_entry_t o_head
);

  iq_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  // NOTE: storage has no reset; only pointers/count do, and the head is zeroed while empty.
  always_ff @(posedge clk_in) begin
    if (i_en && i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues one word fetch at a time, pre-decodes JAL
// for an immediate redirect and buffers words in inst_queue for the decoder.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic [31:0]               flush_pc_in,
  inst_fetch_unit_if.master         fetch_bus
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;

  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, w_seq_pc, r_req_addr;
  logic        r_drop, w_drop_nxt;
  logic        w_is_jal, w_push, w_pop, w_slot_free, w_full, w_empty;
  logic [CW-1:0] w_count;
  iq_entry_t   w_push_entry, w_head;

  assign w_is_jal     = (fetch_bus.mem_resp_data[6:0] == JAL_OP);
  assign w_seq_pc     = w_is_jal ? r_pc + j_imm(fetch_bus.mem_resp_data) : r_pc + 32'd4;
  assign w_push       = (r_state == ST_WAIT) && fetch_bus.mem_resp_valid && !flush_in;
  assign w_pop        = !w_empty && fetch_bus.inst_ready && !flush_in;
  assign w_slot_free  = (int'(w_count) + 1 - int'(w_pop)) < IQ_DEPTH;
  assign w_push_entry = '{pred: w_is_jal, pc: r_pc, word: fetch_bus.mem_resp_data};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: if (!flush_in && !w_full) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (fetch_bus.mem_req_ready)
          w_state_nxt = (r_drop || flush_in) ? ST_DROP : ST_WAIT;
        else if (flush_in)
          w_drop_nxt = 1'b1;
      end
      ST_WAIT: begin
        if (flush_in) begin
          w_state_nxt = fetch_bus.mem_resp_valid ? ST_IDLE : ST_DROP;
        end else if (fetch_bus.mem_resp_valid) begin
          w_pc_nxt    = w_seq_pc;
          w_state_nxt = w_slot_free ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        // The single outstanding word is the stale one, even if a new flush lands now.
        if (fetch_bus.mem_resp_valid) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush_in) w_pc_nxt = {flush_pc_in[31:2], 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_drop     <= 1'b0;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      // Address is captured on entry to REQ so a flush cannot move a pending request.
      if (w_state_nxt == ST_REQ && r_state != ST_REQ)
        r_req_addr <= {w_pc_nxt[31:2], 2'b00};
    end
  end

  inst_queue #(.DEPTH(IQ_DEPTH)) u_queue (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_en     (rdy_in),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_clear  (flush_in),
    .i_data   (w_push_entry),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count),
    .o_head   (w_head)
  );

  assign fetch_bus.mem_req_valid   = (r_state == ST_REQ);
  assign fetch_bus.mem_req_addr    = r_req_addr;
  assign fetch_bus.inst_valid      = !w_empty;
  assign fetch_bus.inst            = w_head.word;
  assign fetch_bus.inst_pc         = w_head.pc;
  assign fetch_bus.inst_pred_taken = w_head.pred;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a memory-controller model serving a program table,
// and a program-walk model of the instruction stream the decoder must see.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          IQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic [31:0] flush_pc;

  inst_fetch_unit_if ifc ();

  inst_fetch_unit #(.RESET_PC(RESET_PC), .IQ_DEPTH(IQ_DEPTH)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .rdy_in      (rdy),
    .flush_in    (flush),
    .flush_pc_in (flush_pc),
    .fetch_bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Program: word, "is JAL" flag and jump offset per word slot (addr[9:2]).
  logic [31:0] prog     [256];
  bit          prog_jal [256];
  logic [31:0] prog_off [256];

  // Controller model state and knobs.
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          ready_pct;
  int          resp_lat;
  bit          holdoff;

  // Stream model and logs.
  logic [31:0] exp_pc;
  logic [31:0] acc_log [$];
  logic [31:0] pop_pc_log [$];
  bit          pop_pred_log [$];
  bit          last_rsp;

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return prog_jal[idx(pc)] ? pc + prog_off[idx(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] enc_addi();
    return {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_branch();
    return {7'($urandom), 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int off, input logic [4:0] rd);
    logic [20:0] imm;
    imm = 21'(off);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w, input bit jal, input logic [31:0] off);
    prog[idx(a)]     = w;
    prog_jal[idx(a)] = jal;
    prog_off[idx(a)] = off;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) set_word(32'(i * 4), enc_addi(), 1'b0, 32'd0);
  endtask

  task automatic fill_program(input int jal_pct);
    for (int i = 0; i < 256; i++) begin
      int r, off;
      r = int'($urandom_range(99));
      if (r < jal_pct) begin
        off = (int'($urandom_range(32)) - 16) * 4;
        if (off == 0) off = 8;
        set_word(32'(i * 4), enc_jal(off, 5'($urandom)), 1'b1, 32'(off));
      end else if (r < jal_pct + 10) begin
        set_word(32'(i * 4), enc_branch(), 1'b0, 32'd0);
      end else begin
        set_word(32'(i * 4), enc_addi(), 1'b0, 32'd0);
      end
    end
  endtask

  task automatic drive_ctrl();
    ifc.mem_req_ready  = !holdoff && ($urandom_range(99) < ready_pct);
    ifc.mem_resp_valid = !holdoff && rdy && pend && (pend_wait == 0);
    ifc.mem_resp_data  = pend ? prog[idx(pend_addr)] : 32'($urandom);
  endtask

  // One clock: drive the controller, check any pop against the stream model,
  // advance the clock and update controller/model state.
  task automatic tick();
    bit acc, rsp, pop, fl;
    logic [31:0] acc_addr;
    drive_ctrl();
    acc      = rst_n && rdy && ifc.mem_req_valid && ifc.mem_req_ready;
    rsp      = rst_n && ifc.mem_resp_valid;
    fl       = rst_n && rdy && flush;
    pop      = rst_n && rdy && !flush && ifc.inst_valid && ifc.inst_ready;
    acc_addr = ifc.mem_req_addr;
    if (pop) begin
      n_checks++;
      if (ifc.inst_pc !== exp_pc || ifc.inst !== prog[idx(exp_pc)] ||
          ifc.inst_pred_taken !== prog_jal[idx(exp_pc)]) begin
        n_fail++;
        $display("FAIL stream: got pc=%h inst=%h pred=%b, expected pc=%h inst=%h pred=%b",
                 ifc.inst_pc, ifc.inst, ifc.inst_pred_taken,
                 exp_pc, prog[idx(exp_pc)], prog_jal[idx(exp_pc)]);
      end
      pop_pc_log.push_back(ifc.inst_pc);
      pop_pred_log.push_back(ifc.inst_pred_taken);
      exp_pc = next_pc(exp_pc);
    end
    if (acc) begin
      n_checks++;
      if (pend || acc_addr[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL req_protocol: outstanding=%0b addr=%h, expected none outstanding and aligned addr",
                 pend, acc_addr);
      end
      acc_log.push_back(acc_addr);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pend   = 1'b0;
      exp_pc = RESET_PC;
    end else begin
      if (rsp) pend = 1'b0;
      else if (pend && rdy && !holdoff && pend_wait > 0) pend_wait--;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
        pend_wait = resp_lat;
      end
      if (fl) begin
        exp_pc = {flush_pc[31:2], 2'b00};
        n_checks++;
        if (ifc.inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_empties: inst_valid=%b, expected 0", ifc.inst_valid);
        end
      end
    end
    last_rsp = rsp;
  endtask

  task automatic wait_acc(input int n, input int max_cyc, output bit ok);
    int c;
    c = 0;
    while (acc_log.size() < n && c < max_cyc) begin
      tick();
      c++;
    end
    ok = (acc_log.size() >= n);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; flush_pc = '0;
    ifc.inst_ready = 1'b0; holdoff = 1'b0; ready_pct = 100; resp_lat = 0;
    tick(); tick();
    rst_n = 1'b1;
    acc_log.delete(); pop_pc_log.delete(); pop_pred_log.delete();
  endtask

  task automatic test_reset();
    fill_linear();
    rst_n = 1'b0; rdy = 1'b0; flush = 1'b0; flush_pc = '0;
    ifc.inst_ready = 1'b1; holdoff = 1'b0; ready_pct = 100; resp_lat = 0;
    tick(); tick();
    n_checks++; if (ifc.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", ifc.mem_req_valid); end
    n_checks++; if (ifc.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", ifc.inst_valid); end
    n_checks++; if (ifc.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", ifc.inst); end
    n_checks++; if (ifc.inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 0", ifc.inst_pc); end
    n_checks++; if (ifc.inst_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %b expected 0", ifc.inst_pred_taken); end
    rst_n = 1'b1; rdy = 1'b1; ifc.inst_ready = 1'b0; ready_pct = 0;
    tick();
    n_checks++;
    if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: valid=%b addr=%h, expected 1 and %h", ifc.mem_req_valid, ifc.mem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_fill();
    bit seen;
    fill_linear();
    apply_reset();
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (last_rsp && !seen) begin
        seen = 1'b1;
        n_checks++;
        if (ifc.inst_valid !== 1'b1) begin n_fail++; $display("FAIL resp_latency: inst_valid=%b expected 1", ifc.inst_valid); end
      end
    end
    n_checks++;
    if (acc_log.size() != IQ_DEPTH) begin n_fail++; $display("FAIL fill_req_count: got %0d expected %0d", acc_log.size(), IQ_DEPTH); end
    for (int i = 0; i < acc_log.size() && i < IQ_DEPTH; i++) begin
      n_checks++;
      if (acc_log[i] !== RESET_PC + 32'(4 * i)) begin
        n_fail++; $display("FAIL fill_req_addr[%0d]: got %h expected %h", i, acc_log[i], RESET_PC + 32'(4 * i));
      end
    end
    n_checks++; if (ifc.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_stops_req: got %b expected 0", ifc.mem_req_valid); end
    n_checks++; if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== RESET_PC) begin
      n_fail++; $display("FAIL fill_head: valid=%b pc=%h expected 1 and %h", ifc.inst_valid, ifc.inst_pc, RESET_PC);
    end
  endtask

  task automatic test_jal();
    bit found_acc, found_pop;
    fill_linear();
    set_word(32'h10, 32'h100000EF, 1'b1, 32'h100);
    apply_reset();
    ifc.inst_ready = 1'b1;
    repeat (40) tick();
    found_acc = 1'b0;
    for (int i = 0; i + 1 < acc_log.size(); i++) begin
      if (acc_log[i] == 32'h10 && !found_acc) begin
        found_acc = 1'b1;
        n_checks++;
        if (acc_log[i+1] !== 32'h110) begin n_fail++; $display("FAIL jal_redirect: got %h expected 00000110", acc_log[i+1]); end
      end
    end
    found_pop = 1'b0;
    for (int i = 0; i < pop_pc_log.size(); i++) begin
      if (pop_pc_log[i] == 32'h10 && !found_pop) begin
        found_pop = 1'b1;
        n_checks++;
        if (pop_pred_log[i] !== 1'b1) begin n_fail++; $display("FAIL jal_pred: got %b expected 1", pop_pred_log[i]); end
      end
    end
    n_checks++;
    if (!found_acc || !found_pop) begin n_fail++; $display("FAIL jal_seen: req=%b pop=%b expected 1 1", found_acc, found_pop); end
  endtask

  task automatic test_flush_wait();
    bit ok;
    fill_linear();
    apply_reset();
    resp_lat = 3;
    wait_acc(2, 50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_wait_setup: accepts=%0d expected 2", acc_log.size()); end
    flush = 1'b1; flush_pc = 32'h0000_2003;
    tick();
    flush = 1'b0;
    acc_log.delete(); pop_pc_log.delete();
    wait_acc(1, 40, ok);
    n_checks++;
    if (!ok || acc_log[0] !== 32'h2000) begin
      n_fail++; $display("FAIL flush_wait_req: got %h expected 00002000", ok ? acc_log[0] : 32'hx);
    end
    ifc.inst_ready = 1'b1;
    repeat (15) tick();
    n_checks++;
    if (pop_pc_log.size() == 0 || pop_pc_log[0] !== 32'h2000) begin
      n_fail++; $display("FAIL flush_wait_head: pops=%0d first=%h expected 00002000", pop_pc_log.size(),
                         pop_pc_log.size() ? pop_pc_log[0] : 32'hx);
    end
  endtask

  task automatic test_flush_req();
    bit ok;
    int c;
    fill_linear();
    apply_reset();
    ready_pct = 0;
    c = 0;
    while (ifc.mem_req_valid !== 1'b1 && c < 10) begin tick(); c++; end
    flush = 1'b1; flush_pc = 32'h0000_3008;
    for (int k = 0; k < 3; k++) begin
      tick();
      flush = 1'b0;
      n_checks++;
      if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== RESET_PC) begin
        n_fail++; $display("FAIL flush_req_hold[%0d]: valid=%b addr=%h expected 1 and %h", k, ifc.mem_req_valid, ifc.mem_req_addr, RESET_PC);
      end
    end
    ready_pct = 100;
    acc_log.delete(); pop_pc_log.delete();
    wait_acc(2, 40, ok);
    n_checks++;
    if (!ok || acc_log[0] !== RESET_PC || acc_log[1] !== 32'h3008) begin
      n_fail++; $display("FAIL flush_req_seq: accepts=%0d first=%h second=%h expected %h then 00003008",
                         acc_log.size(), acc_log.size() > 0 ? acc_log[0] : 32'hx, acc_log.size() > 1 ? acc_log[1] : 32'hx, RESET_PC);
    end
    ifc.inst_ready = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (pop_pc_log.size() == 0 || pop_pc_log[0] !== 32'h3008) begin
      n_fail++; $display("FAIL flush_req_head: pops=%0d expected first pc 00003008", pop_pc_log.size());
    end
  endtask

  task automatic test_back_to_back();
    fill_linear();
    apply_reset();
    repeat (20) tick();
    pop_pc_log.delete();
    for (int c = 0; c < 60; c++) begin
      ifc.inst_ready = (c < 8) ? 1'b1 : 1'($urandom);
      tick();
    end
    n_checks++;
    if (pop_pc_log.size() < 12) begin n_fail++; $display("FAIL b2b_throughput: pops=%0d expected >= 12", pop_pc_log.size()); end
    for (int i = 0; i < pop_pc_log.size(); i++) begin
      n_checks++;
      if (pop_pc_log[i] !== RESET_PC + 32'(4 * i)) begin
        n_fail++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, pop_pc_log[i], RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_freeze();
    bit ok;
    fill_linear();
    apply_reset();
    wait_acc(2, 30, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL freeze_setup: accepts=%0d expected 2", acc_log.size()); end
    holdoff = 1'b1; rdy = 1'b0; flush = 1'b1; flush_pc = 32'h5000; ifc.inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (ifc.mem_req_valid !== 1'b0 || ifc.inst_valid !== 1'b1 || ifc.inst !== prog[0] ||
          ifc.inst_pc !== RESET_PC || ifc.inst_pred_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d]: req=%b valid=%b inst=%h pc=%h pred=%b expected 0 1 %h %h 0",
                 k, ifc.mem_req_valid, ifc.inst_valid, ifc.inst, ifc.inst_pc, ifc.inst_pred_taken, prog[0], RESET_PC);
      end
    end
    rdy = 1'b1; flush = 1'b0; holdoff = 1'b0; ifc.inst_ready = 1'b0;
    acc_log.delete();
    wait_acc(1, 20, ok);
    n_checks++;
    if (!ok || acc_log[0] !== RESET_PC + 32'd8 || ifc.inst_pc !== RESET_PC) begin
      n_fail++; $display("FAIL freeze_resume: accepts=%0d head=%h expected next req %h head %h",
                         acc_log.size(), ifc.inst_pc, RESET_PC + 32'd8, RESET_PC);
    end
  endtask

  task automatic test_random();
    int pops_before;
    fill_program(12);
    apply_reset();
    pops_before = 0;
    ready_pct = int'($urandom_range(30, 100));
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) ready_pct = int'($urandom_range(30, 100));
      resp_lat       = int'($urandom_range(0, 3));
      ifc.inst_ready = ($urandom_range(99) < 60);
      rdy            = ($urandom_range(99) >= 5);
      flush          = ($urandom_range(99) < 3);
      flush_pc       = {20'h0, 12'($urandom)};
      tick();
    end
    flush = 1'b0; rdy = 1'b1;
    n_checks++;
    if (pop_pc_log.size() < 200) begin n_fail++; $display("FAIL random_progress: pops=%0d expected >= 200", pop_pc_log.size()); end
  endtask

  initial begin
    pend = 1'b0; pend_wait = 0; pend_addr = '0; exp_pc = RESET_PC; last_rsp = 1'b0;
    ifc.mem_req_ready = 1'b0; ifc.mem_resp_valid = 1'b0; ifc.mem_resp_data = '0; ifc.inst_ready = 1'b0;
    test_reset();
    test_fill();
    test_jal();
    test_flush_wait();
    test_flush_req();
    test_back_to_back();
    test_freeze();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
